msg_sim_scheduler: RTL and testbench

Sequencing controller for the 128-bit message simulation generator. It issues one-cycle start pulses to the generator and waits for each frame-done pulse. It inserts a programmable idle gap between frames, advances the frame counter fed to the generator header, and stops after N frames, on a stop request, or on a watchdog timeout. It sits between the control/register interface and the generator's `msg_sim_en_i` / `msg_done_pluse_o` pair.

---
 rtl/msg_sim_scheduler_pkg.sv | 21 ++
 rtl/msg_sim_scheduler_if.sv | 22 ++
 rtl/msg_sim_scheduler_cycle_timer.sv | 31 +++
 rtl/msg_sim_scheduler.sv | 175 +++++++++++++++++
 tb/tb_msg_sim_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_sim_scheduler_pkg.sv
// Shared definitions for the message simulation sequencer: state encoding,
// frame counter width, watchdog default and the frame-count step helper.
package msg_sim_pkg;

    localparam int unsigned FRAME_CNT_W     = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 4096;
    localparam int unsigned TIMER_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    // Frame count advances modulo 2**FRAME_CNT_W (0xFFFF rolls to 0x0000).
    function automatic logic [FRAME_CNT_W-1:0] frame_cnt_next(input logic [FRAME_CNT_W-1:0] cnt);
        return cnt + FRAME_CNT_W'(1);
    endfunction

endpackage

// File: rtl/msg_sim_scheduler_if.sv
// Start/done handshake and frame header count between the scheduler (master)
// and the message generator (slave).
interface msg_sim_scheduler_if;
    import msg_sim_pkg::*;

    logic                   msg_sim_en_o;
    logic                   msg_done_pluse_i;
    logic [FRAME_CNT_W-1:0] sim_frame_cnt_o;

    modport master (
        output msg_sim_en_o,
        output sim_frame_cnt_o,
        input  msg_done_pluse_i
    );

    modport slave (
        input  msg_sim_en_o,
        input  sim_frame_cnt_o,
        output msg_done_pluse_i
    );

endinterface

// File: rtl/msg_sim_scheduler_cycle_timer.sv
// Load/decrement down counter with a zero flag; shared by the inter-frame gap
// and the frame-done watchdog since those phases never overlap.
module msg_sim_cycle_timer
    import msg_sim_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         sys_clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_r;

    // Load has priority; decrement saturates at zero so the flag stays stable.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            count_r <= {W{1'b0}};
        end else if (load_i) begin
            count_r <= load_val_i;
        end else if (dec_i && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end
    end

    assign zero_o = (count_r == {W{1'b0}});

endmodule

// File: rtl/msg_sim_scheduler.sv
// Frame sequencer for the message simulation generator: issues start pulses,
// waits for done, spaces frames by a programmable gap and ends runs cleanly.
module msg_sim_scheduler
    import msg_sim_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned SENT_W      = 32
) (
    input  logic                   sys_clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [15:0]            cfg_frame_num_i,
    input  logic [31:0]            cfg_gap_i,
    input  logic [FRAME_CNT_W-1:0] cfg_cnt_init_i,
    msg_sim_scheduler_if.master    gen_if,
    output logic                   busy_o,
    output logic                   run_done_o,
    output logic [SENT_W-1:0]      frames_sent_o,
    output logic                   timeout_err_o
);

    // Watchdog fires when the counter hits zero, i.e. on the TIMEOUT_CYC-th WAIT edge.
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYC - 1);

    sched_state_t           state_r;
    logic [15:0]            cfg_frame_num_r;
    logic [31:0]            cfg_gap_r;
    logic                   stop_pend_r;
    logic                   en_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic                   busy_r;
    logic                   run_done_r;
    logic [SENT_W-1:0]      frames_sent_r;
    logic                   timeout_err_r;

    logic                   done_s;
    logic [SENT_W-1:0]      frames_inc_s;
    logic                   last_frame_s;
    logic                   end_on_done_s;
    logic                   tmr_load_s;
    logic                   tmr_dec_s;
    logic [TIMER_W-1:0]     tmr_load_val_s;
    logic                   tmr_zero_s;

    msg_sim_cycle_timer #(
        .W (TIMER_W)
    ) u_cycle_timer (
        .sys_clk_i  (sys_clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_load_val_s),
        .dec_i      (tmr_dec_s),
        .zero_o     (tmr_zero_s)
    );

    // Run-end decision on done and timer control for the current state.
    always_comb begin
        done_s         = gen_if.msg_done_pluse_i;
        frames_inc_s   = frames_sent_r + SENT_W'(1);
        last_frame_s   = (cfg_frame_num_r != 16'd0) && (frames_inc_s == SENT_W'(cfg_frame_num_r));
        end_on_done_s  = stop_pend_r | stop_i | last_frame_s;
        tmr_load_s     = 1'b0;
        tmr_dec_s      = 1'b0;
        tmr_load_val_s = {TIMER_W{1'b0}};
        case (state_r)
            ST_ISSUE: begin
                tmr_load_s     = 1'b1;
                tmr_load_val_s = TIMEOUT_LOAD;
            end
            ST_WAIT: begin
                if (done_s && !end_on_done_s && (cfg_gap_r != 32'd0)) begin
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = cfg_gap_r - 32'd1;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_GAP: begin
                tmr_dec_s = 1'b1;
            end
            default: begin
                tmr_load_s = 1'b0;
                tmr_dec_s  = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered outputs; en and run_done default low so both are single-cycle pulses.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_r         <= ST_IDLE;
            cfg_frame_num_r <= 16'd0;
            cfg_gap_r       <= 32'd0;
            stop_pend_r     <= 1'b0;
            en_r            <= 1'b0;
            frame_cnt_r     <= {FRAME_CNT_W{1'b0}};
            busy_r          <= 1'b0;
            run_done_r      <= 1'b0;
            frames_sent_r   <= {SENT_W{1'b0}};
            timeout_err_r   <= 1'b0;
        end else begin
            en_r       <= 1'b0;
            run_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        cfg_frame_num_r <= cfg_frame_num_i;
                        cfg_gap_r       <= cfg_gap_i;
                        frame_cnt_r     <= cfg_cnt_init_i;
                        frames_sent_r   <= {SENT_W{1'b0}};
                        timeout_err_r   <= 1'b0;
                        stop_pend_r     <= 1'b0;
                        en_r            <= 1'b1;
                        busy_r          <= 1'b1;
                        state_r         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (stop_i) begin
                        stop_pend_r <= 1'b1;
                    end
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_s) begin
                        frame_cnt_r   <= frame_cnt_next(frame_cnt_r);
                        frames_sent_r <= frames_inc_s;
                        if (end_on_done_s) begin
                            stop_pend_r <= 1'b0;
                            busy_r      <= 1'b0;
                            run_done_r  <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else if (cfg_gap_r == 32'd0) begin
                            en_r    <= 1'b1;
                            state_r <= ST_ISSUE;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else if (tmr_zero_s) begin
                        timeout_err_r <= 1'b1;
                        stop_pend_r   <= 1'b0;
                        busy_r        <= 1'b0;
                        run_done_r    <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else if (stop_i) begin
                        stop_pend_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (stop_i) begin
                        busy_r     <= 1'b0;
                        run_done_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else if (tmr_zero_s) begin
                        en_r    <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gen_if.msg_sim_en_o    = en_r;
    assign gen_if.sim_frame_cnt_o = frame_cnt_r;
    assign busy_o                 = busy_r;
    assign run_done_o             = run_done_r;
    assign frames_sent_o          = frames_sent_r;
    assign timeout_err_o          = timeout_err_r;

endmodule

// File: tb/tb_msg_sim_scheduler.sv
// Bench for msg_sim_scheduler: generator models answer each en after a set
// delay; pulse timing and counts are predicted arithmetically per run.
module tb_msg_sim_scheduler;

    logic        sys_clk = 1'b0;
    logic        rst_i, start_i, stop_i;
    logic [15:0] cfg_frame_num, cfg_cnt_init;
    logic [31:0] cfg_gap;
    logic        busy, run_done, timeout_err;
    logic [31:0] frames_sent;
    logic        t_busy, t_run_done, t_timeout_err;
    logic [31:0] t_frames_sent;

    msg_sim_scheduler_if gen_if();
    msg_sim_scheduler_if gen_t_if();

    msg_sim_scheduler #(.TIMEOUT_CYC(4096), .SENT_W(32)) dut (
        .sys_clk_i(sys_clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .cfg_frame_num_i(cfg_frame_num), .cfg_gap_i(cfg_gap), .cfg_cnt_init_i(cfg_cnt_init),
        .gen_if(gen_if), .busy_o(busy), .run_done_o(run_done),
        .frames_sent_o(frames_sent), .timeout_err_o(timeout_err));

    msg_sim_scheduler #(.TIMEOUT_CYC(16), .SENT_W(32)) dut_t (
        .sys_clk_i(sys_clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .cfg_frame_num_i(cfg_frame_num), .cfg_gap_i(cfg_gap), .cfg_cnt_init_i(cfg_cnt_init),
        .gen_if(gen_t_if), .busy_o(t_busy), .run_done_o(t_run_done),
        .frames_sent_o(t_frames_sent), .timeout_err_o(t_timeout_err));

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gen_pend = -1;
    int gen_delay = 40;
    int t_pend   = -1;
    int t_delay  = 0;
    int en_q[$];
    int rd_q[$];
    int trd_q[$];
    logic [15:0] cnt_q[$];
    logic [15:0] cntd_q[$];

    // One clock: sample outputs after the edge, then drive generator done for the next edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc = cyc + 1;
        if (gen_if.msg_sim_en_o) begin
            en_q.push_back(cyc);
            cnt_q.push_back(gen_if.sim_frame_cnt_o);
            gen_pend = cyc + gen_delay - 1;
        end
        if (run_done) rd_q.push_back(cyc);
        if (gen_t_if.msg_sim_en_o) t_pend = (t_delay > 0) ? cyc + t_delay - 1 : -1;
        if (t_run_done) trd_q.push_back(cyc);
        gen_if.msg_done_pluse_i = (cyc == gen_pend);
        if (cyc == gen_pend) cntd_q.push_back(gen_if.sim_frame_cnt_o);
        gen_t_if.msg_done_pluse_i = (cyc == t_pend);
    endtask

    task automatic clear_q();
        en_q.delete(); rd_q.delete(); trd_q.delete(); cnt_q.delete(); cntd_q.delete();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        n_checks++; if (gen_if.msg_sim_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", gen_if.msg_sim_en_o); end
        n_checks++; if (gen_if.sim_frame_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", gen_if.sim_frame_cnt_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (run_done !== 1'b0) begin n_fail++; $display("FAIL reset_run_done got %b want 0", run_done); end
        n_checks++; if (frames_sent !== 32'd0) begin n_fail++; $display("FAIL reset_frames got %0d want 0", frames_sent); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
        rst_i = 1'b0;
        repeat (2) tick();
    endtask

    // Run n frames (gap g, generator delay d), optionally holding start for `hold` cycles.
    task automatic run_check(input string name, input int n, input int g, input logic [15:0] init,
                             input int d, input int hold);
        int k;
        int budget;
        int exp_rd;
        clear_q();
        cfg_frame_num = 16'(n); cfg_gap = 32'(g); cfg_cnt_init = init; gen_delay = d;
        start_i = 1'b1;
        tick();
        k = cyc;
        cfg_frame_num = 16'($urandom); cfg_gap = $urandom; cfg_cnt_init = 16'($urandom);
        budget = n * (d + g) + 20;
        for (int i = 0; i < budget && rd_q.size() == 0; i++) begin
            start_i = (cyc < k + hold);
            tick();
        end
        start_i = 1'b0;
        repeat (6) tick();
        exp_rd = k + n * d + (n - 1) * g;
        n_checks++; if (en_q.size() != n) begin n_fail++; $display("FAIL %s en_count got %0d want %0d", name, en_q.size(), n); end
        n_checks++; if (cntd_q.size() != n) begin n_fail++; $display("FAIL %s done_count got %0d want %0d", name, cntd_q.size(), n); end
        for (int i = 0; i < n && i < en_q.size(); i++) begin
            n_checks++; if (en_q[i] != k + i * (d + g)) begin n_fail++; $display("FAIL %s en_time[%0d] got %0d want %0d", name, i, en_q[i] - k, i * (d + g)); end
            n_checks++; if (cnt_q[i] !== 16'(init + i)) begin n_fail++; $display("FAIL %s cnt_at_en[%0d] got %h want %h", name, i, cnt_q[i], 16'(init + i)); end
        end
        for (int i = 0; i < n && i < cntd_q.size(); i++) begin
            n_checks++; if (cntd_q[i] !== 16'(init + i)) begin n_fail++; $display("FAIL %s cnt_at_done[%0d] got %h want %h", name, i, cntd_q[i], 16'(init + i)); end
        end
        n_checks++;
        if (rd_q.size() != 1) begin n_fail++; $display("FAIL %s run_done_count got %0d want 1", name, rd_q.size()); end
        else if (rd_q[0] != exp_rd) begin n_fail++; $display("FAIL %s run_done_time got %0d want %0d", name, rd_q[0] - k, exp_rd - k); end
        n_checks++; if (frames_sent !== 32'(n)) begin n_fail++; $display("FAIL %s frames_sent got %0d want %0d", name, frames_sent, n); end
        n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL %s idle_flags got busy=%b err=%b want 0 0", name, busy, timeout_err); end
    endtask

    task automatic test_stop_wait();
        int k;
        int d = 10;
        int g = 2;
        logic [15:0] init;
        init = 16'($urandom);
        clear_q();
        cfg_frame_num = 16'd0; cfg_gap = 32'(g); cfg_cnt_init = init; gen_delay = d;
        start_i = 1'b1; tick(); k = cyc; start_i = 1'b0;
        for (int i = 0; i < 200 && rd_q.size() == 0; i++) begin
            stop_i = (en_q.size() == 4) && (cyc == en_q[3] + 5);
            tick();
        end
        stop_i = 1'b0;
        repeat (20) tick();
        n_checks++; if (en_q.size() != 4) begin n_fail++; $display("FAIL stop_wait en_count got %0d want 4", en_q.size()); end
        n_checks++;
        if (rd_q.size() != 1) begin n_fail++; $display("FAIL stop_wait run_done_count got %0d want 1", rd_q.size()); end
        else if (rd_q[0] != k + 3 * (d + g) + d) begin n_fail++; $display("FAIL stop_wait run_done_time got %0d want %0d", rd_q[0] - k, 3 * (d + g) + d); end
        n_checks++; if (frames_sent !== 32'd4) begin n_fail++; $display("FAIL stop_wait frames_sent got %0d want 4", frames_sent); end
        n_checks++; if (gen_if.sim_frame_cnt_o !== 16'(init + 4)) begin n_fail++; $display("FAIL stop_wait cnt got %h want %h", gen_if.sim_frame_cnt_o, 16'(init + 4)); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_wait busy got %b want 0", busy); end
    endtask

    task automatic test_stop_gap();
        int k;
        int d = 6;
        clear_q();
        cfg_frame_num = 16'd0; cfg_gap = 32'd8; cfg_cnt_init = 16'h0200; gen_delay = d;
        start_i = 1'b1; tick(); k = cyc; start_i = 1'b0;
        for (int i = 0; i < 100 && rd_q.size() == 0; i++) begin
            stop_i = (cyc == k + d + 3);
            tick();
        end
        stop_i = 1'b0;
        repeat (30) tick();
        n_checks++;
        if (rd_q.size() != 1) begin n_fail++; $display("FAIL stop_gap run_done_count got %0d want 1", rd_q.size()); end
        else if (rd_q[0] != k + d + 4) begin n_fail++; $display("FAIL stop_gap run_done_time got %0d want %0d", rd_q[0] - k, d + 4); end
        n_checks++; if (en_q.size() != 1) begin n_fail++; $display("FAIL stop_gap en_count got %0d want 1", en_q.size()); end
        n_checks++; if (frames_sent !== 32'd1) begin n_fail++; $display("FAIL stop_gap frames_sent got %0d want 1", frames_sent); end
    endtask

    task automatic test_start_stop();
        clear_q();
        cfg_frame_num = 16'd2; cfg_gap = 32'd0; cfg_cnt_init = 16'h0007; gen_delay = 5;
        start_i = 1'b1; stop_i = 1'b1;
        repeat (3) tick();
        start_i = 1'b0; stop_i = 1'b0;
        repeat (3) tick();
        n_checks++; if (en_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL start_stop launch got en=%0d busy=%b want 0 0", en_q.size(), busy); end
    endtask

    task automatic test_reset_mid_run();
        int bad = 0;
        clear_q();
        cfg_frame_num = 16'd0; cfg_gap = 32'd0; cfg_cnt_init = 16'h0ABC; gen_delay = 30;
        start_i = 1'b1; tick(); start_i = 1'b0;
        repeat (9) tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        n_checks++;
        if (gen_if.msg_sim_en_o !== 1'b0 || gen_if.sim_frame_cnt_o !== 16'h0000 || busy !== 1'b0 ||
            run_done !== 1'b0 || frames_sent !== 32'd0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid outputs got en=%b cnt=%h busy=%b rd=%b sent=%0d err=%b want all 0",
                     gen_if.msg_sim_en_o, gen_if.sim_frame_cnt_o, busy, run_done, frames_sent, timeout_err);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b0 || run_done !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0 || en_q.size() != 1) begin n_fail++; $display("FAIL rst_mid late_done got bad=%0d en=%0d want 0 1", bad, en_q.size()); end
        n_checks++; if (frames_sent !== 32'd0) begin n_fail++; $display("FAIL rst_mid frames_sent got %0d want 0", frames_sent); end
    endtask

    // Watchdog on the TIMEOUT_CYC=16 instance: no done, done on the timeout edge, done one edge late.
    task automatic t_run(input string name, input int delay, input logic exp_err, input int exp_sent,
                         input logic [15:0] init);
        int k;
        clear_q();
        t_delay = delay; cfg_frame_num = 16'd1; cfg_gap = 32'd0; cfg_cnt_init = init;
        start_i = 1'b1; tick(); k = cyc; start_i = 1'b0;
        n_checks++; if (t_timeout_err !== 1'b0 || t_busy !== 1'b1) begin n_fail++; $display("FAIL %s start got err=%b busy=%b want 0 1", name, t_timeout_err, t_busy); end
        for (int i = 0; i < 60 && trd_q.size() == 0; i++) tick();
        n_checks++;
        if (trd_q.size() != 1) begin n_fail++; $display("FAIL %s run_done_count got %0d want 1", name, trd_q.size()); end
        else if (trd_q[0] != k + 17) begin n_fail++; $display("FAIL %s run_done_time got %0d want 17", name, trd_q[0] - k); end
        n_checks++; if (t_timeout_err !== exp_err) begin n_fail++; $display("FAIL %s timeout_err got %b want %b", name, t_timeout_err, exp_err); end
        n_checks++; if (t_frames_sent !== 32'(exp_sent)) begin n_fail++; $display("FAIL %s frames_sent got %0d want %0d", name, t_frames_sent, exp_sent); end
        n_checks++; if (gen_t_if.sim_frame_cnt_o !== 16'(init + exp_sent)) begin n_fail++; $display("FAIL %s cnt got %h want %h", name, gen_t_if.sim_frame_cnt_o, 16'(init + exp_sent)); end
        repeat (4) tick();
        n_checks++; if (t_timeout_err !== exp_err || t_busy !== 1'b0) begin n_fail++; $display("FAIL %s after got err=%b busy=%b want %b 0", name, t_timeout_err, t_busy, exp_err); end
    endtask

    task automatic test_timeout();
        rst_i = 1'b1; repeat (2) tick(); rst_i = 1'b0; tick();
        gen_delay = 5;
        t_run("timeout_none", 0, 1'b1, 0, 16'h1234);
        t_run("timeout_tie", 17, 1'b0, 1, 16'h1234);
        t_run("timeout_late", 18, 1'b1, 0, 16'h5678);
        t_delay = 0;
    endtask

    task automatic test_random();
        int n, g, d, hold;
        logic [15:0] init;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 4);
            g = $urandom_range(0, 6);
            d = $urandom_range(2, 20);
            hold = $urandom_range(0, d);
            init = 16'($urandom);
            run_check("random", n, g, init, d, hold);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        cfg_frame_num = 16'd0; cfg_gap = 32'd0; cfg_cnt_init = 16'd0;
        gen_if.msg_done_pluse_i = 1'b0;
        gen_t_if.msg_done_pluse_i = 1'b0;
        test_reset();
        run_check("normal", 3, 0, 16'h0010, 40, 0);
        run_check("gap5", 2, 5, 16'h0100, 12, 0);
        run_check("wrap", 3, 1, 16'hFFFE, 7, 0);
        run_check("start_busy", 2, 3, 16'h0042, 10, 10);
        test_stop_wait();
        test_stop_gap();
        test_start_stop();
        test_reset_mid_run();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
